// File: rtl/spi_fetch_ctrl.sv
// spi_fetch_ctrl: SPI mode-0 serial-memory read controller, req/rvalid handshake.
// Define SPI_SEQ_BURST_EN for sequential burst (HOLD state, CS kept low).
module spi_fetch_ctrl #(
  parameter int         ADDR_W   = 16,
  parameter int         DATA_W   = 16,
  parameter int         CLK_DIV  = 1,
  parameter int         CS_HIGH  = 2,
  parameter logic [7:0] CMD_READ = 8'h03
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req,
  input  logic [ADDR_W-1:0] addr,
  output logic [DATA_W-1:0] rdata,
  output logic              rvalid,
  output logic              busy,
  output logic              spi_cs_n,
  output logic              spi_sck,
  output logic              spi_mosi,
  input  logic              spi_miso
);
  localparam int SW  = 8 + ADDR_W;
  localparam int MB  = (ADDR_W > DATA_W) ? ADDR_W : DATA_W;
  localparam int BW  = $clog2(MB);
  localparam int DVW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int HW  = (CS_HIGH > 1) ? $clog2(CS_HIGH) : 1;

  localparam logic [DVW-1:0] DIV_END = DVW'(CLK_DIV - 1);
  localparam logic [HW-1:0]  HI_END  = HW'(CS_HIGH - 1);

`ifdef SPI_SEQ_BURST_EN
  typedef enum logic [2:0] {
    IDLE, CMD, ADDR, DATA, DESEL, HOLD
  } state_t;
  localparam logic [ADDR_W-1:0] STEP = ADDR_W'(DATA_W / 8);
`else
  typedef enum logic [2:0] {
    IDLE, CMD, ADDR, DATA, DESEL
  } state_t;
`endif

  state_t            state;
  logic [SW-1:0]     tx;
  logic [DATA_W-1:0] rx;
  logic [BW-1:0]     bit_cnt;
  logic [DVW-1:0]    div_cnt;
  logic [HW-1:0]     hi_cnt;
  logic [ADDR_W-1:0] start_addr;
  logic              tick;

`ifdef SPI_SEQ_BURST_EN
  logic              pend;
  logic [ADDR_W-1:0] addr_q;
  logic [ADDR_W-1:0] seq_addr;

  // a deferred non-sequential request restarts with its latched address
  assign start_addr = pend ? addr_q : addr;
  assign seq_addr   = addr_q + STEP;
`else
  assign start_addr = addr;
`endif

  // end of the current sck half period
  assign tick = (div_cnt == DIV_END);

  // controller state machine, SPI bit engine and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      tx       <= '0;
      rx       <= '0;
      bit_cnt  <= '0;
      div_cnt  <= '0;
      hi_cnt   <= '0;
      rdata    <= '0;
      rvalid   <= 1'b0;
      busy     <= 1'b0;
      spi_cs_n <= 1'b1;
      spi_sck  <= 1'b0;
      spi_mosi <= 1'b0;
`ifdef SPI_SEQ_BURST_EN
      pend     <= 1'b0;
      addr_q   <= '0;
`endif
    end else begin
      rvalid <= 1'b0;
      case (state)
        IDLE: begin
`ifdef SPI_SEQ_BURST_EN
          if (req || pend) begin
            addr_q <= start_addr;
            pend   <= 1'b0;
`else
          if (req) begin
`endif
            tx       <= {CMD_READ[6:0], start_addr, 1'b0};
            spi_mosi <= CMD_READ[7];
            spi_cs_n <= 1'b0;
            spi_sck  <= 1'b0;
            div_cnt  <= '0;
            bit_cnt  <= BW'(7);
            busy     <= 1'b1;
            state    <= CMD;
          end
        end
        CMD, ADDR, DATA: begin
          if (!tick) begin
            div_cnt <= div_cnt + 1'b1;
          end else if (!spi_sck) begin
            div_cnt <= '0;
            spi_sck <= 1'b1;
          end else begin
            div_cnt <= '0;
            spi_sck <= 1'b0;
            rx      <= {rx[DATA_W-2:0], spi_miso};
            if (bit_cnt != '0) begin
              bit_cnt  <= bit_cnt - 1'b1;
              spi_mosi <= (state == DATA) ? 1'b0 : tx[SW-1];
              tx       <= tx << 1;
            end else begin
              case (state)
                CMD: begin
                  spi_mosi <= tx[SW-1];
                  tx       <= tx << 1;
                  bit_cnt  <= BW'(ADDR_W - 1);
                  state    <= ADDR;
                end
                ADDR: begin
                  spi_mosi <= 1'b0;
                  bit_cnt  <= BW'(DATA_W - 1);
                  state    <= DATA;
                end
                default: begin
                  rdata  <= {rx[DATA_W-2:0], spi_miso};
                  rvalid <= 1'b1;
`ifdef SPI_SEQ_BURST_EN
                  busy   <= 1'b0;
                  state  <= HOLD;
`else
                  spi_cs_n <= 1'b1;
                  hi_cnt   <= HI_END;
                  state    <= DESEL;
`endif
                end
              endcase
            end
          end
        end
        DESEL: begin
          if (hi_cnt == '0) begin
`ifdef SPI_SEQ_BURST_EN
            busy  <= pend;
`else
            busy  <= 1'b0;
`endif
            state <= IDLE;
          end else begin
            hi_cnt <= hi_cnt - 1'b1;
          end
        end
`ifdef SPI_SEQ_BURST_EN
        HOLD: begin
          if (req) begin
            addr_q <= addr;
            busy   <= 1'b1;
            if (addr == seq_addr) begin
              spi_mosi <= 1'b0;
              spi_sck  <= 1'b0;
              div_cnt  <= '0;
              bit_cnt  <= BW'(DATA_W - 1);
              state    <= DATA;
            end else begin
              spi_cs_n <= 1'b1;
              hi_cnt   <= HI_END;
              pend     <= 1'b1;
              state    <= DESEL;
            end
          end
        end
`endif
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_spi_fetch_ctrl.sv
// tb_spi_fetch_ctrl: two controller configurations, each with an SPI SRAM model
// and a scoreboard of expected words, latencies and bus activity.
module tb_spi_fetch_ctrl;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_chk = 0;
  int n_fail = 0;

`ifdef SPI_SEQ_BURST_EN
  localparam bit BURST = 1'b1;
`else
  localparam bit BURST = 1'b0;
`endif

  task automatic check(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  for (genvar g = 0; g < 2; g++) begin : s
    localparam int AW = (g == 0) ? 16 : 24;
    localparam int DW = (g == 0) ? 16 : 32;
    localparam int DV = (g == 0) ? 1 : 3;
    localparam int CH = 2;
    localparam int N  = 8 + AW + DW;
    localparam logic [AW-1:0] STEP = AW'(DW / 8);
    localparam logic [AW-1:0] SA = AW'((g == 0) ? 32'h0012 : 32'hABCDEF);
    localparam logic [DW-1:0] SD = DW'((g == 0) ? 32'hBEEF : 32'h12345678);

    logic          rst, req, rvalid, busy, cs_n, sck, mosi;
    logic          miso = 1'b0;
    logic [AW-1:0] addr;
    logic [DW-1:0] rdata;
    bit            done = 1'b0;
    bit            sck_chk = 1'b0;

    spi_fetch_ctrl #(
      .ADDR_W(AW), .DATA_W(DW), .CLK_DIV(DV),
      .CS_HIGH(CH), .CMD_READ(8'h03)
    ) dut (
      .clk(clk), .rst(rst), .req(req), .addr(addr),
      .rdata(rdata), .rvalid(rvalid), .busy(busy),
      .spi_cs_n(cs_n), .spi_sck(sck), .spi_mosi(mosi),
      .spi_miso(miso)
    );

    function automatic logic [DW-1:0] mem(input logic [AW-1:0] a);
      logic [63:0] t;
      t = {32'(a), ~32'(a)} ^ 64'h5A5A_3C3C_9696_A5A5;
      if (a == SA) return SD;
      return t[DW-1:0];
    endfunction

    // SPI SRAM model: header on sck rise, data streamed on sck fall
    int            hcnt = 0;
    int            dbit = 0;
    int            rises = 0;
    logic [8+AW-1:0] hsh;
    logic [8+AW-1:0] hq[$];
    logic [AW-1:0] ptr;
    logic [DW-1:0] w;

    always @(negedge cs_n) begin
      hcnt = 0;
      dbit = 0;
    end

    always @(posedge sck) begin
      rises++;
      if (!cs_n && hcnt < 8 + AW) begin
        hsh = {hsh[8+AW-2:0], mosi};
        hcnt++;
        if (hcnt == 8 + AW) begin
          hq.push_back(hsh);
          ptr = hsh[AW-1:0];
        end
      end
    end

    always @(negedge sck) begin
      if (!cs_n && hcnt == 8 + AW) begin
        w = mem(ptr);
        miso = w[DW-1-dbit];
        dbit++;
        if (dbit == DW) begin
          dbit = 0;
          ptr = ptr + STEP;
        end
      end
    end

    // scoreboard: push on acceptance, pop and compare on rvalid
    logic [DW-1:0] qd[$];
    int            ql[$];
    int            qr[$];
    bit            qc[$];
    bit            qh[$];
    logic [AW-1:0] qa[$];
    logic [DW-1:0] ed;
    logic [AW-1:0] ea, last;
    int            el, er, acc, hi_run, run;
    bit            ec, eh, held, seq, cs_hi, prev_cs, sck_prev, fell;

    always @(negedge clk) begin
      if (rst) begin
        qd.delete(); ql.delete(); qr.delete();
        qc.delete(); qh.delete(); qa.delete(); hq.delete();
        held = 1'b0;
        prev_cs = 1'b1;
        hi_run = CH;
        fell = 1'b0;
      end else begin
        if (rvalid) begin
          check("rv_expected", 64'(qd.size() != 0), 64'd1);
          if (qd.size() != 0) begin
            ed = qd.pop_front(); el = ql.pop_front();
            er = qr.pop_front(); ec = qc.pop_front();
            eh = qh.pop_front(); ea = qa.pop_front();
            check("rdata", rdata, ed);
            check("latency", 64'(cyc - acc), 64'(el));
            check("sck_rises", 64'(rises), 64'(er));
            check("cs_gap", cs_hi, ec);
            check("hdr_count", 64'(hq.size()), eh ? 64'd1 : 64'd0);
            if (eh && hq.size() != 0)
              check("hdr", hq.pop_front(), {8'h03, ea});
            check("busy_rv", busy, !BURST);
            check("cs_rv", cs_n, !BURST);
          end
          held = BURST;
        end
        if (cs_n) cs_hi = 1'b1;
        if (cs_n) begin
          hi_run++;
        end else begin
          if (prev_cs) check("cs_min_high", 64'(hi_run >= CH), 64'd1);
          hi_run = 0;
        end
        prev_cs = cs_n;
        if (req && !busy) begin
          seq = held && (addr == AW'(last + STEP));
          qd.push_back(mem(addr));
          ql.push_back(2 * DV * (seq ? DW : N) +
                       ((held && !seq) ? CH + 1 : 0));
          qr.push_back(seq ? DW : N);
          qc.push_back(held && !seq);
          qh.push_back(!seq);
          qa.push_back(addr);
          last = addr;
          held = 1'b0;
          acc = cyc + 1;
          rises = 0;
          cs_hi = 1'b0;
        end
        if (cs_n) fell = 1'b0;
        if (sck != sck_prev) begin
          if (sck_chk && sck_prev) check("sck_high", 64'(run), 64'(DV));
          else if (sck_chk && fell) check("sck_low", 64'(run), 64'(DV));
          fell = sck_prev;
          run = 1;
        end else begin
          run++;
        end
        sck_prev = sck;
      end
    end

    task automatic rst_chk();
      check("rst_cs_n", cs_n, 1);
      check("rst_sck", sck, 0);
      check("rst_mosi", mosi, 0);
      check("rst_rvalid", rvalid, 0);
      check("rst_busy", busy, 0);
      check("rst_rdata", rdata, 0);
    endtask

    task automatic wait_accept();
      int n;
      n = 0;
      while (busy && n < 3000) begin
        @(negedge clk);
        n++;
      end
      if (busy) check("accept_timeout", busy, 0);
      @(negedge clk);
    endtask

    task automatic wait_rv();
      int n;
      n = 0;
      do begin
        @(negedge clk);
        n++;
      end while (!rvalid && n < 3000);
      if (!rvalid) check("rvalid_timeout", rvalid, 1);
    endtask

    task automatic fetch(input logic [AW-1:0] a);
      req = 1'b1;
      addr = a;
      wait_accept();
      req = 1'b0;
      wait_rv();
    endtask

    if (g == 0) begin : t0
      initial begin
        req = 1'b0; addr = '0; rst = 1'b1;
        repeat (3) @(negedge clk);
        rst_chk();
        rst = 1'b0;
        @(negedge clk);
        fetch(AW'(16'h0012));
        req = 1'b1;
        addr = AW'(16'h0100);
        wait_accept();
        addr = AW'(16'h0200);
        wait_rv();
        wait_accept();
        req = 1'b0;
        wait_rv();
        fetch(AW'(16'h0010));
        fetch(AW'(16'h0012));
        fetch(AW'(16'h0040));
        fetch(AW'(16'hFFFE));
        fetch(AW'(16'h0000));
        req = 1'b1;
        addr = AW'(16'h0034);
        wait_accept();
        req = 1'b0;
        repeat (24) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("abort_cs_n", cs_n, 1);
        check("abort_sck", sck, 0);
        check("abort_rvalid", rvalid, 0);
        check("abort_busy", busy, 0);
        rst = 1'b0;
        @(negedge clk);
        fetch(AW'(16'h0036));
        repeat (10) @(negedge clk);
        done = 1'b1;
      end
    end else begin : t1
      initial begin
        req = 1'b0; addr = '0; rst = 1'b1;
        repeat (3) @(negedge clk);
        rst_chk();
        rst = 1'b0;
        @(negedge clk);
        sck_chk = 1'b1;
        fetch(AW'(32'hABCDEF));
        fetch(AW'(32'h000100));
        sck_chk = 1'b0;
        repeat (10) @(negedge clk);
        done = 1'b1;
      end
    end
  end

  initial begin
    for (int i = 0; i < 40000; i++) begin
      if (s[0].done && s[1].done) break;
      @(negedge clk);
    end
    check("all_done", {s[0].done, s[1].done}, 2'b11);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end
endmodule
